// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with valid/ready handshakes
// on the operand and result sides. It handles one multiplier bit per cycle and
// supports signed and unsigned operands, selected per operation.
// Optional feature macro MUL_ACC_EN adds the acc_en port and a 2*WIDTH
// accumulator. When acc_en is latched high, the new result is added to the
// previous product.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef MUL_ACC_EN
  input  logic               acc_en,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]    pp_r;
  logic [CNT_W-1:0] count_r;
  logic             neg_r;
  logic             accept_s;
  logic             done_hs_s;
  logic [WIDTH:0]   add_s;
  logic [PW-1:0]    shifted_s;
  logic [PW-1:0]    result_s;
  logic [PW-1:0]    final_s;
`ifdef MUL_ACC_EN
  logic [PW-1:0]    acc_r;
  logic             acc_sel_r;
`endif

  // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
    logic [WIDTH-1:0] m;
    if (sm && v[WIDTH-1]) begin
      m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's-complement negation over the full product width
  function automatic logic [PW-1:0] negate_pp(input logic [PW-1:0] v);
    return ~v + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign done_hs_s = (state_r == DONE) && out_ready;

  // Shift-add step and final sign fix-up / accumulation
  always_comb begin
    add_s     = {1'b0, pp_r[PW-1:WIDTH]} + (mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    shifted_s = {add_s, pp_r[WIDTH-1:1]};
    if (neg_r) begin
      result_s = negate_pp(pp_r);
    end else begin
      result_s = pp_r;
    end
`ifdef MUL_ACC_EN
    if (acc_sel_r) begin
      final_s = result_s + acc_r;
    end else begin
      final_s = result_s;
    end
`else
    final_s = result_s;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_CNT) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX: state_nxt_s = DONE;
      DONE: begin
        if (done_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN:  busy = 1'b1;
      FIX:  busy = 1'b1;
      DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result/accumulator load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      pp_r      <= '0;
      count_r   <= '0;
      neg_r     <= 1'b0;
      product   <= '0;
`ifdef MUL_ACC_EN
      acc_r     <= '0;
      acc_sel_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r   <= magnitude(a, signed_mode);
            mplier_r  <= magnitude(b, signed_mode);
            neg_r     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            pp_r      <= '0;
            count_r   <= '0;
`ifdef MUL_ACC_EN
            acc_sel_r <= acc_en;
`endif
          end
        end
        RUN: begin
          pp_r     <= shifted_s;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          product <= final_s;
`ifdef MUL_ACC_EN
          acc_r   <= final_s;
`endif
        end
        DONE: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier. It runs WIDTH=8 directed vectors and
// corner sequences, plus a WIDTH=16 randomized sweep against an arithmetic
// reference model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, sm8 = 1'b0, acc8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, sm16 = 1'b0, acc16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] product16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8),
`ifdef MUL_ACC_EN
    .acc_en(acc8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(sm16),
`ifdef MUL_ACC_EN
    .acc_en(acc16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .product(product16), .busy(busy16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one WIDTH=8 operation; returns the product and cycles from acceptance to out_valid
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm, input logic tacc,
                     output logic [15:0] prod, output int lat);
    int w = 0;
    while (!in_ready8 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("in_ready8_timeout", 64'd0, 64'd1);
    a8 = ta; b8 = tb; sm8 = tsm; acc8 = tacc; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    prod = product8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("in_ready8_after_hs", {63'd0, in_ready8}, 64'd1);
  endtask

  // Issue one WIDTH=16 operation
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                      output logic [31:0] prod, output int lat);
    int w = 0;
    while (!in_ready16 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("in_ready16_timeout", 64'd0, 64'd1);
    a16 = ta; b16 = tb; sm16 = tsm; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    prod = product16;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec8_t;

  initial begin
    vec8_t       vt[8];
    logic [15:0] p8;
    logic [31:0] p16;
    int          lat;
    longint      ea, eb;
    logic [31:0] exp16;

    vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[2] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vt[3] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vt[4] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    vt[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vt[6] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vt[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

    // Reset state
    #1;
    chk("rst_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_product", {48'd0, product8}, 64'd0);
    chk("rst_product16", {32'd0, product16}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, each with latency check
    for (int i = 0; i < 8; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].sm, 1'b0, p8, lat);
      chk($sformatf("vec%0d_product", i), {48'd0, p8}, {48'd0, vt[i].exp});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
    end

    // Backpressure: result held while out_ready is low, new operands ignored
    a8 = 8'd3; b8 = 8'd2; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("bp_busy_after_accept", {63'd0, busy8}, 64'd1);
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    a8 = 8'd9; b8 = 8'd9; in_valid8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_product", {48'd0, product8}, 64'h6);
      chk("bp_in_ready", {63'd0, in_ready8}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid8}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("bp_idle_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("bp_idle_busy", {63'd0, busy8}, 64'd0);
    chk("bp_idle_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("bp_idle_product_held", {48'd0, product8}, 64'h6);
    op8(8'd2, 8'd2, 1'b0, 1'b0, p8, lat);
    chk("bp_next_op", {48'd0, p8}, 64'h4);

    // Reset in the middle of RUN aborts the operation
    a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("midrst_product", {48'd0, product8}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready8}, 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("postrst_out_valid", {63'd0, out_valid8}, 64'd0);
    op8(8'd7, 8'd9, 1'b0, 1'b0, p8, lat);
    chk("postrst_7x9", {48'd0, p8}, 64'h3F);

`ifdef MUL_ACC_EN
    // Accumulate mode
    op8(8'd3, 8'd4, 1'b0, 1'b0, p8, lat);
    chk("acc_3x4", {48'd0, p8}, 64'h000C);
    op8(8'd5, 8'd6, 1'b0, 1'b1, p8, lat);
    chk("acc_5x6", {48'd0, p8}, 64'h002A);
    op8(8'd0, 8'd0, 1'b0, 1'b0, p8, lat);
    chk("acc_clear", {48'd0, p8}, 64'h0000);
    op8(8'hFF, 8'h01, 1'b1, 1'b1, p8, lat);
    chk("acc_neg1", {48'd0, p8}, 64'hFFFF);
    op8(8'hFF, 8'h01, 1'b1, 1'b1, p8, lat);
    chk("acc_wrap", {48'd0, p8}, 64'hFFFE);
    op8(8'h02, 8'h01, 1'b0, 1'b1, p8, lat);
    chk("acc_wrap_pos", {48'd0, p8}, 64'h0000);
`endif

    // WIDTH=16 random sweep against plain arithmetic
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (n == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
      if (n == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0; end
      if (rs) begin
        ea = longint'($signed(ra));
        eb = longint'($signed(rb));
      end else begin
        ea = longint'(ra);
        eb = longint'(rb);
      end
      exp16 = 32'(ea * eb);
      op16(ra, rb, rs, p16, lat);
      chk($sformatf("sweep%0d_product", n), {32'd0, p16}, {32'd0, exp16});
      chk($sformatf("sweep%0d_latency", n), 64'(lat), 64'd17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
